calc_mul_seq: RTL and testbench

Sequential unsigned shift-add multiplier for the calculator datapath. It is the multiply counterpart to the combinational restoring divider: `calc_div` turns a dividend into a quotient and remainder, and this block rebuilds a full-width product from two operands. It processes one multiplier bit per clock behind a start/busy/done handshake, so the control FSM can share one result register path with the divider.

---
 rtl/calc_mul_seq.sv | 74 +++++++
 tb/tb_calc_mul_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/calc_mul_seq.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock,
// start/busy/done handshake, full 2*W-bit product with a W-bit overflow flag.
module calc_mul_seq #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   P,
  output logic             ovf
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [2*W-1:0]    mcand;
  logic [W-1:0]      mplr;
  logic [2*W-1:0]    acc;
  logic [CW-1:0]     cnt;
  logic [2*W-1:0]    sum;

  // Partial-product accumulation for the current iteration; cannot overflow 2*W bits.
  assign sum = acc + (mplr[0] ? mcand : {(2*W){1'b0}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= {{W{1'b0}}, A};
            mplr  <= B;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          // Fixed latency: terminate on the W-th iteration regardless of mplr.
          if (cnt == CW'(W - 1)) begin
            P     <= sum;
            ovf   <= |sum[2*W-1:W];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_mul_seq.sv
// Scoreboard bench for calc_mul_seq: stimulus pushes expected products,
// a negedge monitor pops and checks value, overflow and completion cycle.
module tb_calc_mul_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;
  logic           ovf;

  typedef struct {
    logic [2*W-1:0] p;
    logic           ovf;
    int             due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  calc_mul_seq #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", int'(P), int'(e.p));
        check("ovf", int'(ovf), int'(e.ovf));
        check("latency", cyc, e.due);
        check("busy_low_at_done", int'(busy), 0);
      end
    end
  end

  // Called at a negedge; leaves the caller at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] ep, input logic eovf);
    exp_t e;
    A     = a;
    B     = b;
    start = 1'b1;
    e.p   = ep;
    e.ovf = eovf;
    e.due = cyc + 1 + W;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("completion_timeout", sb.size(), 0);
  endtask

  task automatic wait_done_neg();
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("done_seen", seen, 1);
  endtask

  initial begin
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] rp;

    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_P", int'(P), 0);
    check("rst_ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic, maximum and zero operands
    start_op(8'd13, 8'd11, 16'h008F, 1'b0);
    wait_idle();
    start_op(8'd255, 8'd255, 16'hFE01, 1'b1);
    wait_idle();
    start_op(8'd0, 8'd200, 16'h0000, 1'b0);
    wait_idle();
    check("P_held_idle", int'(P), 0);

    // Start and operand changes while busy are ignored
    start_op(8'd16, 8'd16, 16'h0100, 1'b1);
    repeat (2) @(negedge clk);
    A = 8'd3;
    B = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 8'd99;
    B = 8'd77;
    wait_idle();
    repeat (12) @(negedge clk);

    // Back-to-back: second start issued during the done cycle
    start_op(8'd7, 8'd9, 16'h003F, 1'b0);
    wait_done_neg();
    start_op(8'd20, 8'd20, 16'h0190, 1'b1);
    wait_idle();

    // Asynchronous reset between edges k+4 and k+5
    start_op(8'd100, 8'd3, 16'd300, 1'b1);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_P", int'(P), 0);
    check("midrst_ovf", int'(ovf), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_P", int'(P), 0);
    start_op(8'd5, 8'd5, 16'h0019, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);

    // Random sweep against a behavioural model
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rp = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
      start_op(ra, rb, rp, (rp > 16'd255));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
